regfile_multiport: RTL

- Parametrised successor to the single-write, two-read CPU register file.
- Provides three read ports (Rn, Rm, Rs operands) and two write ports (result writeback and base-register writeback for load/store with writeback).
- Provides a dedicated program-counter register with a read offset, synchronous reset, same-cycle write-to-read bypass, and an optional registered-read mode.
- Sits between the decode stage (read addresses) and the writeback stage (write ports); the fetch unit drives the PC input.

---
 rtl/regfile_multiport.sv | 116 +++++++++++
 1 files changed

// File: rtl/regfile_multiport.sv
// Multiport CPU register file: three read ports, two write ports and a
// dedicated program-counter register with read offset, optional same-cycle
// write-to-read bypass and optional registered reads.
module regfile_multiport #(
   parameter int unsigned         DATA_W    = 32,
   parameter int unsigned         ADDR_W    = 4,
   parameter int unsigned         PC_IDX    = 15,
   parameter logic [DATA_W-1:0]   PC_OFFSET = DATA_W'(8),
   parameter logic [DATA_W-1:0]   RESET_PC  = '0,
   parameter bit                  BYPASS    = 1'b1,
   parameter bit                  READ_REG  = 1'b0
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic [ADDR_W-1:0] addr_a_in,
   input  logic [ADDR_W-1:0] addr_b_in,
   input  logic [ADDR_W-1:0] addr_c_in,
   output logic [DATA_W-1:0] data_a_out,
   output logic [DATA_W-1:0] data_b_out,
   output logic [DATA_W-1:0] data_c_out,
   input  logic              we0_in,
   input  logic [ADDR_W-1:0] waddr0_in,
   input  logic [DATA_W-1:0] wdata0_in,
   input  logic              we1_in,
   input  logic [ADDR_W-1:0] waddr1_in,
   input  logic [DATA_W-1:0] wdata1_in,
   input  logic              pc_en_in,
   input  logic [DATA_W-1:0] pc_in,
   output logic [DATA_W-1:0] pc_out,
   output logic              wr_conflict_out
);

   localparam int unsigned       DEPTH   = 2 ** ADDR_W;
   localparam int unsigned       N_RD    = 3;
   localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

   logic [DATA_W-1:0] regs    [DEPTH];
   logic [ADDR_W-1:0] rd_addr [N_RD];
   logic [DATA_W-1:0] rd_sel  [N_RD];

   // Gather read addresses so all ports share one selection loop
   always_comb begin
      rd_addr[0] = addr_a_in;
      rd_addr[1] = addr_b_in;
      rd_addr[2] = addr_c_in;
   end

   // Per-port read value: optional bypass from this cycle's writes, then PC offset
   always_comb begin
      for (int p = 0; p < N_RD; p++) begin
         rd_sel[p] = regs[rd_addr[p]];
         if (BYPASS) begin
            if (we0_in && (waddr0_in == rd_addr[p])) begin
               rd_sel[p] = wdata0_in;
            end else if (we1_in && (waddr1_in == rd_addr[p])) begin
               rd_sel[p] = wdata1_in;
            end else if (pc_en_in && (rd_addr[p] == PC_ADDR)) begin
               rd_sel[p] = pc_in;
            end
         end
         if (rd_addr[p] == PC_ADDR) begin
            rd_sel[p] = rd_sel[p] + PC_OFFSET;
         end
      end
   end

   // Register array update: port 0 beats port 1 beats the fetch PC load
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= (ADDR_W'(i) == PC_ADDR) ? RESET_PC : '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (we0_in && (waddr0_in == ADDR_W'(i))) begin
               regs[i] <= wdata0_in;
            end else if (we1_in && (waddr1_in == ADDR_W'(i))) begin
               regs[i] <= wdata1_in;
            end else if (pc_en_in && (ADDR_W'(i) == PC_ADDR)) begin
               regs[i] <= pc_in;
            end
         end
      end
   end

   // One-cycle flag when both write ports hit the same register
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         wr_conflict_out <= 1'b0;
      end else begin
         wr_conflict_out <= we0_in && we1_in && (waddr0_in == waddr1_in);
      end
   end

   assign pc_out = regs[PC_ADDR];

   if (READ_REG) begin : g_rd_reg
      // Capture the bypass-selected read values; data appears one cycle later
      always_ff @(posedge clk_in) begin
         if (reset_in) begin
            data_a_out <= '0;
            data_b_out <= '0;
            data_c_out <= '0;
         end else begin
            data_a_out <= rd_sel[0];
            data_b_out <= rd_sel[1];
            data_c_out <= rd_sel[2];
         end
      end
   end else begin : g_rd_comb
      assign data_a_out = rd_sel[0];
      assign data_b_out = rd_sel[1];
      assign data_c_out = rd_sel[2];
   end

endmodule
